// File: rtl/shift_request_sequencer.sv
// shift_request_sequencer: FIFO-buffered request front end for the combinational 8-bit right shifter
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_data/in_shift request stream;
// sh_memory/sh_shift drive the shifter, sh_shout returns its result; out_valid/out_ready/out_data/out_shift
// result stream; count is FIFO occupancy; err is a sticky result-check flag, present only with
// SHIFT_SEQ_CHECK_EN defined (tied to 0 otherwise).
module shift_request_sequencer #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 8,
  parameter int SHIFT_W = 3
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  output logic [DATA_W-1:0]        sh_memory,
  output logic [SHIFT_W-1:0]       sh_shift,
  input  logic [DATA_W-1:0]        sh_shout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SHIFT_W-1:0]       out_shift,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [SHIFT_W-1:0] fifo_shift [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic               iss_vld, res_vld;
  logic [DATA_W-1:0]  iss_data, res_data;
  logic [SHIFT_W-1:0] iss_shift, res_shift;
  logic               push, res_take, iss_load;
  assign in_ready  = !reset && (count < (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready;
  assign res_take  = iss_vld && (!res_vld || out_ready);
  assign iss_load  = (count != '0) && (!iss_vld || res_take);
  assign sh_memory = iss_vld ? iss_data : '0;
  assign sh_shift  = iss_vld ? iss_shift : '0;
  assign out_valid = res_vld;
  assign out_data  = res_data;
  assign out_shift = res_shift;
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= in_data;
      fifo_shift[wr_ptr] <= in_shift;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      iss_vld   <= 1'b0;
      iss_data  <= '0;
      iss_shift <= '0;
      res_vld   <= 1'b0;
      res_data  <= '0;
      res_shift <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (iss_load) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, iss_load};
      if (iss_load) begin
        iss_vld   <= 1'b1;
        iss_data  <= fifo_data[rd_ptr];
        iss_shift <= fifo_shift[rd_ptr];
      end else if (res_take) iss_vld <= 1'b0;
      if (res_take) begin
        res_vld   <= 1'b1;
        res_data  <= sh_shout;
        res_shift <= iss_shift;
      end else if (res_vld && out_ready) res_vld <= 1'b0;
    end
  end
`ifdef SHIFT_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (res_take && (sh_shout != (iss_data >> iss_shift))) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_request_sequencer.sv
// tb_shift_request_sequencer: table vectors, corner sequences and a queue-model random run
module tb_shift_request_sequencer;
  logic       clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic       in_ready, out_valid, err;
  logic [7:0] in_data = 0, sh_memory, sh_shout, out_data;
  logic [2:0] in_shift = 0, sh_shift, out_shift;
  logic [2:0] count;
  logic       force_en = 0;
  logic [7:0] force_val = 0;
  int nvec = 0, nerr = 0;
  logic err_exp;

  shift_request_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift(in_shift), .sh_memory(sh_memory), .sh_shift(sh_shift),
    .sh_shout(sh_shout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift), .count(count), .err(err)
  );

  assign sh_shout = force_en ? force_val : (sh_memory >> sh_shift);
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [2:0] s; logic [7:0] e; } vec_t;
  vec_t tbl[9];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic single(input logic [7:0] d, input logic [2:0] s, input logic [7:0] e);
    out_ready = 1; in_valid = 1; in_data = d; in_shift = s;
    @(negedge clk);
    in_valid = 0;
    chk("acc_count", count, 1);
    chk("acc_ov", out_valid, 0);
    @(negedge clk);
    chk("iss_mem", sh_memory, d);
    chk("iss_shift", sh_shift, s);
    chk("iss_count", count, 0);
    chk("iss_ov", out_valid, 0);
    @(negedge clk);
    chk("res_ov", out_valid, 1);
    chk("res_data", out_data, e);
    chk("res_shift", out_shift, s);
    @(negedge clk);
    chk("res_clr", out_valid, 0);
    chk("iss_idle_mem", sh_memory, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #2;
    reset = 0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd[6];
    logic [2:0] rs[6];
    logic [7:0] re[6];
    logic [10:0] q[$];
    logic stall, hold_v;
    logic [7:0] hold_d;
`ifdef SHIFT_SEQ_CHECK_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    tbl[0] = '{8'hB4, 3'd2, 8'h2D};
    tbl[1] = '{8'hFF, 3'd0, 8'hFF};
    tbl[2] = '{8'hFF, 3'd7, 8'h01};
    tbl[3] = '{8'h80, 3'd1, 8'h40};
    tbl[4] = '{8'h01, 3'd0, 8'h01};
    tbl[5] = '{8'h01, 3'd1, 8'h00};
    tbl[6] = '{8'hA5, 3'd4, 8'h0A};
    tbl[7] = '{8'h7E, 3'd3, 8'h0F};
    tbl[8] = '{8'hC3, 3'd5, 8'h06};

    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_shift", out_shift, 0);
    chk("rst_count", count, 0);
    chk("rst_sh_memory", sh_memory, 0);
    chk("rst_sh_shift", sh_shift, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) single(tbl[i].d, tbl[i].s, tbl[i].e);

    // back-to-back boundary shifts
    out_ready = 1; in_valid = 1; in_data = 8'hFF; in_shift = 0;
    @(negedge clk);
    in_shift = 7;
    @(negedge clk);
    in_valid = 0;
    chk("b2b_ov0", out_valid, 0);
    @(negedge clk);
    chk("b2b_ov1", out_valid, 1);
    chk("b2b_d1", out_data, 8'hFF);
    @(negedge clk);
    chk("b2b_ov2", out_valid, 1);
    chk("b2b_d2", out_data, 8'h01);
    chk("b2b_s2", out_shift, 7);
    @(negedge clk);
    chk("b2b_end", out_valid, 0);

    // backpressure: six requests fill result, issue and FIFO
    for (int k = 0; k < 6; k++) begin
      rd[k] = 8'($urandom); rs[k] = 3'($urandom); re[k] = rd[k] >> rs[k];
    end
    out_ready = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_data = rd[k]; in_shift = rs[k];
      chk("bp_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 0;
    chk("bp_count", count, 4);
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_ov", out_valid, 1);
    chk("bp_data", out_data, re[0]);
    chk("bp_iss", sh_memory, rd[1]);
    @(negedge clk);
    @(negedge clk);
    chk("bp_hold_d", out_data, re[0]);
    chk("bp_hold_s", out_shift, rs[0]);
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_drain_v", out_valid, 1);
      chk("bp_drain_d", out_data, re[k]);
      chk("bp_drain_s", out_shift, rs[k]);
      @(negedge clk);
    end
    chk("bp_drained", out_valid, 0);
    chk("bp_count0", count, 0);

    // simultaneous push and pop at count 2
    for (int k = 0; k < 5; k++) begin
      rd[k] = 8'($urandom); rs[k] = 3'($urandom); re[k] = rd[k] >> rs[k];
    end
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = rd[k]; in_shift = rs[k];
      @(negedge clk);
    end
    chk("pp_count_pre", count, 2);
    chk("pp_d0", out_data, re[0]);
    out_ready = 1; in_valid = 1; in_data = rd[4]; in_shift = rs[4];
    @(negedge clk);
    in_valid = 0;
    chk("pp_count", count, 2);
    for (int k = 1; k < 5; k++) begin
      chk("pp_v", out_valid, 1);
      chk("pp_d", out_data, re[k]);
      @(negedge clk);
    end
    chk("pp_end", out_valid, 0);

    // reset with requests in flight
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = 8'h11 * (k + 1); in_shift = 3'(k);
      @(negedge clk);
    end
    in_valid = 0;
    chk("mr_pre_ov", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("mr_ov", out_valid, 0);
    chk("mr_rdy", in_ready, 0);
    chk("mr_count", count, 0);
    chk("mr_mem", sh_memory, 0);
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mr_stale", out_valid, 0);
    end

    // randomized run against a queue model
    stall = 0; hold_v = 0; hold_d = 0;
    for (int c = 0; c < 3000; c++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          chk("rnd_data", out_data, q[0][7:0]);
          chk("rnd_shift", out_shift, q[0][10:8]);
        end
      end
      if (stall) begin
        chk("rnd_hold_v", out_valid, 1);
        chk("rnd_hold_d", out_data, hold_d);
      end
      if (q.size() > 6) chk("rnd_occupancy", q.size(), 6);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_shift = 3'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) q.push_back({in_shift, in_data >> in_shift});
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      stall = out_valid && !out_ready;
      hold_d = out_data;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid) begin
        chk("drain_data", out_data, q[0][7:0]);
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_ov", out_valid, 0);

    // result checker
    force_en = 1; force_val = 8'h80;
    out_ready = 1; in_valid = 1; in_data = 8'h80; in_shift = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("err_data", out_data, 8'h80);
    chk("err_set", err, err_exp);
    force_en = 0;
    @(negedge clk);
    single(8'h10, 3'd1, 8'h08);
    chk("err_sticky", err, err_exp);
    do_reset();
    chk("err_clr", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
